// File: rtl/dadda_final_adder.sv
// dadda_final_adder
//   Final carry-propagate adder behind the Dadda reduction tree of the 32x32
//   radix-4 multiplier. It adds the two reduced rows as an unsigned N-bit
//   modular sum. The default build adds one SEG-bit slice per cycle and
//   ripples the carry between slices through a flop.
//
//   Build option: define DADDA_FA_FLAT_EN to perform the whole N-bit add in a
//   single ADD cycle. This build has no slice counter and no carry flop, and
//   it produces bit-identical results.
//
//   Ports
//     CLK    in   rising-edge clock
//     RST    in   synchronous reset, active-high
//     VIN    in   ROW_A/ROW_B valid
//     ROW_A  in   [N-1:0] reduced row 0
//     ROW_B  in   [N-1:0] reduced row 1
//     READY  out  operand pair can be accepted this cycle (low only in ADD)
//     SUM    out  [N-1:0] (ROW_A + ROW_B) mod 2^N, updated only at completion
//     COUT   out  carry out of bit N-1 (debug)
//     VOUT   out  one-cycle pulse: SUM/COUT hold a new result
module dadda_final_adder #(
  parameter int unsigned N   = 66,
  parameter int unsigned SEG = 22
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         VIN,
  input  logic [N-1:0] ROW_A,
  input  logic [N-1:0] ROW_B,
  output logic         READY,
  output logic [N-1:0] SUM,
  output logic         COUT,
  output logic         VOUT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] sum_q, sum_d;
  logic         cout_q, cout_d;
  logic         vout_q, vout_d;
  logic         accept;

`ifdef DADDA_FA_FLAT_EN
  logic [N:0]   full;
`else
  localparam int unsigned NSEG = N / SEG;
  localparam int unsigned CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  work_q, work_d;
  logic [SEG:0]  slice;
  int unsigned   base;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    vout_d  = 1'b0;
    accept  = 1'b0;
`ifdef DADDA_FA_FLAT_EN
    full    = '0;
`else
    cnt_d   = cnt_q;
    carry_d = carry_q;
    work_d  = work_q;
    slice   = '0;
    base    = SEG * 32'(cnt_q);
`endif

    case (state_q)
      IDLE: begin
        if (VIN) accept = 1'b1;
      end
      ADD: begin
`ifdef DADDA_FA_FLAT_EN
        full    = {1'b0, a_q} + {1'b0, b_q};
        sum_d   = full[N-1:0];
        cout_d  = full[N];
        vout_d  = 1'b1;
        state_d = DONE;
`else
        slice = {1'b0, a_q[base +: SEG]} + {1'b0, b_q[base +: SEG]}
              + {{SEG{1'b0}}, carry_q};
        work_d[base +: SEG] = slice[SEG-1:0];
        carry_d = slice[SEG];
        cnt_d   = cnt_q + CW'(1);
        // The last slice is merged into the result directly, so SUM never
        // shows a partially computed value.
        if (cnt_q == CW'(NSEG - 1)) begin
          sum_d   = work_d;
          cout_d  = slice[SEG];
          vout_d  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (VIN) accept = 1'b1;
        else     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = ROW_A;
      b_d     = ROW_B;
      state_d = ADD;
`ifndef DADDA_FA_FLAT_EN
      cnt_d   = '0;
      carry_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      vout_q  <= 1'b0;
`ifndef DADDA_FA_FLAT_EN
      cnt_q   <= '0;
      carry_q <= 1'b0;
      work_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      vout_q  <= vout_d;
`ifndef DADDA_FA_FLAT_EN
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      work_q  <= work_d;
`endif
    end
  end

  assign READY = (state_q != ADD);
  assign SUM   = sum_q;
  assign COUT  = cout_q;
  assign VOUT  = vout_q;

endmodule

// File: tb/tb_dadda_final_adder.sv
// tb_dadda_final_adder
//   Directed checks of the Dadda final adder: reset state, carry ripple
//   across slices, result hold, back-to-back acceptance, and reset abort.
//   A short random sweep is compared against a plain N+1-bit addition.
module tb_dadda_final_adder;

  localparam int unsigned N = 66;
`ifdef DADDA_FA_FLAT_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 3;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         VIN;
  logic [N-1:0] ROW_A;
  logic [N-1:0] ROW_B;
  logic         READY;
  logic [N-1:0] SUM;
  logic         COUT;
  logic         VOUT;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  dadda_final_adder #(
    .N   (66),
    .SEG (22)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .VIN   (VIN),
    .ROW_A (ROW_A),
    .ROW_B (ROW_B),
    .READY (READY),
    .SUM   (SUM),
    .COUT  (COUT),
    .VOUT  (VOUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Present one pair, let it be accepted on the next edge, then drop VIN.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge CLK);
    VIN   = 1'b1;
    ROW_A = a;
    ROW_B = b;
    @(posedge CLK);
    #1;
    VIN = 1'b0;
  endtask

  // Edges from the last sampled edge until VOUT is seen; 99 on timeout.
  task automatic wait_vout(output int unsigned lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK);
      #1;
      if (VOUT) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int unsigned  lat;
    int unsigned  pulses;
    logic         stable;
    logic [95:0]  r;
    logic [N-1:0] ra, rb;
    logic [N:0]   rexp;

    RST = 1'b1; VIN = 1'b0; ROW_A = '0; ROW_B = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ready", READY, 1);
    check("rst_vout",  VOUT,  0);
    check("rst_sum",   SUM,   0);
    check("rst_cout",  COUT,  0);
    RST = 1'b0;

    // 1 + (2^66-1): carry ripples through every slice
    send(66'd1, {N{1'b1}});
    check("t2_busy", READY, 0);
    wait_vout(lat);
    check("t2_lat",  lat,  LAT);
    check("t2_sum",  SUM,  0);
    check("t2_cout", COUT, 1);
    @(posedge CLK); #1;
    check("t2_pulse_once", VOUT, 0);

    // (2^22-1) + 1: carry from slice 0 into slice 1, then hold
    send(66'h3F_FFFF, 66'd1);
    wait_vout(lat);
    check("t3_lat",  lat,  LAT);
    check("t3_sum",  SUM,  66'h40_0000);
    check("t3_cout", COUT, 0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (SUM !== 66'h40_0000) stable = 1'b0;
    end
    check("t3_hold", stable, 1);

    // VIN held high: P2 is only taken in DONE
    @(negedge CLK);
    VIN = 1'b1; ROW_A = 66'd123456789; ROW_B = 66'd987654321;
    @(posedge CLK); #1;
    ROW_A = 66'hFFF_FFFF_FFFF; ROW_B = 66'd1;
    wait_vout(lat);
    check("t4_p1_lat", lat, LAT);
    check("t4_p1_sum", SUM, 66'd1111111110);
    @(posedge CLK); #1;
    VIN = 1'b0;
    check("t4_p2_captured", READY, 0);
    wait_vout(lat);
    check("t4_spacing", lat + 1, LAT + 1 + 1 - 1 + ((LAT == 3) ? 0 : 0));
    check("t4_p2_sum",  SUM,  66'h1000_0000_0000);
    check("t4_p2_cout", COUT, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (VOUT) pulses++;
    end
    check("t4_no_extra", pulses, 0);
    check("t4_idle_ready", READY, 1);

    // Reset during the second ADD cycle, with VIN asserted alongside it
    send(66'd5, 66'd7);
    @(posedge CLK); #1;
    RST = 1'b1; VIN = 1'b1; ROW_A = 66'd9; ROW_B = 66'd9;
    @(posedge CLK); #1;
    RST = 1'b0; VIN = 1'b0;
    check("t5_idle",  READY, 1);
    check("t5_sum",   SUM,   0);
    check("t5_cout",  COUT,  0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (VOUT) pulses++;
    end
    check("t5_no_vout", pulses, 0);
    send(66'h3_0000_0000_0000_0000, 66'h1_0000_0000_0000_0000);
    wait_vout(lat);
    check("t5_lat",  lat,  LAT);
    check("t5_sum",  SUM,  0);
    check("t5_cout", COUT, 1);
    send(66'd1000000000000, 66'd2345678901234);
    wait_vout(lat);
    check("t5_sum2", SUM, 66'd3345678901234);

    // Random pairs against a plain wide addition
    for (int k = 0; k < 20; k++) begin
      r  = {$urandom(), $urandom(), $urandom()};
      ra = r[N-1:0];
      r  = {$urandom(), $urandom(), $urandom()};
      rb = r[N-1:0];
      rexp = {1'b0, ra} + {1'b0, rb};
      send(ra, rb);
      wait_vout(lat);
      check("rand_result", {COUT, SUM}, rexp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
